// File: rtl/ram_arbiter_pkg.sv
// Shared constants and FSM encodings for the main-RAM arbiter.
// The PF_* states exist only when RAM_ARB_PREFETCH_EN is defined.
package ram_arbiter_pkg;

    localparam int RAM_ADDR_W = 13;
    localparam int RAM_DATA_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CPU_ISSUE = 3'd1,
        ST_CPU_CAP   = 3'd2,
        ST_VID_ISSUE = 3'd3,
        ST_VID_CAP   = 3'd4
`ifdef RAM_ARB_PREFETCH_EN
        ,
        ST_PF_ISSUE  = 3'd5,
        ST_PF_CAP    = 3'd6
`endif
    } arb_state_e;

    typedef enum logic {
        GNT_VID = 1'b0,
        GNT_CPU = 1'b1
    } grant_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// CPU, video and RAM-port signal bundle. The slave modport is the arbiter;
// the master modport is the surrounding system (CPU decode, video timing, RAM).
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_ack;
    logic              cpu_overrun;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_ack;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_rdata,
        output cpu_rdata, cpu_ack, cpu_overrun, vid_rdata, vid_ack,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_rdata,
        input  cpu_rdata, cpu_ack, cpu_overrun, vid_rdata, vid_ack,
               ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/ram_arb_prefetch_buf.sv
// One-entry video read-ahead buffer: holds address/data, reports hits and
// drops its entry when a CPU write targets the buffered address (RAM_ARB_PREFETCH_EN).
`ifdef RAM_ARB_PREFETCH_EN
module ram_arb_prefetch_buf #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fill_i,
    input  logic [ADDR_W-1:0] fill_addr_i,
    input  logic [DATA_W-1:0] fill_data_i,
    input  logic              consume_i,
    input  logic              snoop_we_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
    input  logic [ADDR_W-1:0] lookup_addr_i,
    output logic              hit_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        valid_d = valid_q;
        if (fill_i) valid_d = 1'b1;
        if (consume_i || (snoop_we_i && snoop_addr_i == addr_q)) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) valid_q <= 1'b0;
        else          valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (fill_i) begin
            addr_q <= fill_addr_i;
            data_q <= fill_data_i;
        end
    end

    assign hit_o   = valid_q && (lookup_addr_i == addr_q);
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule
`endif

// File: rtl/ram_arbiter.sv
// Single-port main RAM arbiter: CPU has priority with bounded latency, video takes the
// remaining slots. Define RAM_ARB_PREFETCH_EN to add the one-entry video read-ahead.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input logic          clk,
    input logic          reset_n,
    ram_arbiter_if.slave bus
);
    arb_state_e        state_q, state_d;
    grant_e            last_q, last_d;
    logic              pend_q, pend_d;
    logic              pend_we_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic [DATA_W-1:0] pend_wdata_q;
    logic              overrun_q, overrun_d;
    logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d, was_wr_q;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
    logic              issue_cpu, cpu_pend, cpu_busy, eff_we;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_wdata;

    // A same-cycle strobe overrides the latch so the newest request is the one issued.
    assign cpu_pend  = bus.cpu_req | pend_q;
    assign eff_we    = bus.cpu_req ? bus.cpu_we    : pend_we_q;
    assign eff_addr  = bus.cpu_req ? bus.cpu_addr  : pend_addr_q;
    assign eff_wdata = bus.cpu_req ? bus.cpu_wdata : pend_wdata_q;
    assign cpu_busy  = (state_q == ST_CPU_ISSUE) || (state_q == ST_CPU_CAP);

`ifdef RAM_ARB_PREFETCH_EN
    logic              pf_hit, pf_valid, pf_fill, pf_consume;
    logic [DATA_W-1:0] pf_data;
    logic [ADDR_W-1:0] vid_last_q, vid_last_d;

    ram_arb_prefetch_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pf (
        .clk          (clk),
        .reset_n      (reset_n),
        .fill_i       (pf_fill),
        .fill_addr_i  (ram_addr_q),
        .fill_data_i  (bus.ram_rdata),
        .consume_i    (pf_consume),
        .snoop_we_i   (issue_cpu & eff_we),
        .snoop_addr_i (eff_addr),
        .lookup_addr_i(bus.vid_addr),
        .hit_o        (pf_hit),
        .valid_o      (pf_valid),
        .data_o       (pf_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vid_last_q <= '0;
        else          vid_last_q <= vid_last_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        issue_cpu   = 1'b0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vid_ack_d   = 1'b0;
        vid_rdata_d = vid_rdata_q;
`ifdef RAM_ARB_PREFETCH_EN
        pf_fill     = 1'b0;
        pf_consume  = 1'b0;
        vid_last_d  = vid_last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // Video wins a tie only right after a CPU grant, so neither side starves.
                if (cpu_pend && !(bus.vid_req && last_q == GNT_CPU)) begin
                    state_d     = ST_CPU_ISSUE;
                    issue_cpu   = 1'b1;
                    ram_en_d    = 1'b1;
                    ram_we_d    = eff_we;
                    ram_addr_d  = eff_addr;
                    ram_wdata_d = eff_wdata;
                    last_d      = GNT_CPU;
                end else if (bus.vid_req) begin
                    last_d = GNT_VID;
`ifdef RAM_ARB_PREFETCH_EN
                    vid_last_d = bus.vid_addr;
                    if (pf_hit) begin
                        vid_ack_d   = 1'b1;
                        vid_rdata_d = pf_data;
                        pf_consume  = 1'b1;
                    end else
`endif
                    begin
                        state_d    = ST_VID_ISSUE;
                        ram_en_d   = 1'b1;
                        ram_addr_d = bus.vid_addr;
                    end
                end
`ifdef RAM_ARB_PREFETCH_EN
                else if (!pf_valid) begin
                    // Prefetch counts as a video grant so a waiting CPU goes next.
                    state_d    = ST_PF_ISSUE;
                    ram_en_d   = 1'b1;
                    ram_addr_d = vid_last_q + ADDR_W'(1);
                    last_d     = GNT_VID;
                end
`endif
            end
            ST_CPU_ISSUE: state_d = ST_CPU_CAP;
            ST_CPU_CAP: begin
                state_d     = ST_IDLE;
                cpu_ack_d   = 1'b1;
                cpu_rdata_d = was_wr_q ? 8'h00 : bus.ram_rdata[7:0];
            end
            ST_VID_ISSUE: state_d = ST_VID_CAP;
            ST_VID_CAP: begin
                state_d     = ST_IDLE;
                vid_ack_d   = 1'b1;
                vid_rdata_d = bus.ram_rdata;
            end
`ifdef RAM_ARB_PREFETCH_EN
            ST_PF_ISSUE: state_d = ST_PF_CAP;
            ST_PF_CAP: begin
                state_d = ST_IDLE;
                pf_fill = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pend_d    = pend_q;
        overrun_d = overrun_q | (bus.cpu_req & (pend_q | cpu_busy));
        if (issue_cpu)        pend_d = 1'b0;
        else if (bus.cpu_req) pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            last_q      <= GNT_VID;
            pend_q      <= 1'b0;
            overrun_q   <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            was_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            vid_ack_q   <= 1'b0;
            vid_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            pend_q      <= pend_d;
            overrun_q   <= overrun_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            was_wr_q    <= ram_we_q;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_ack_q   <= vid_ack_d;
            vid_rdata_q <= vid_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.cpu_req) begin
            pend_we_q    <= bus.cpu_we;
            pend_addr_q  <= bus.cpu_addr;
            pend_wdata_q <= bus.cpu_wdata;
        end
    end

    assign bus.ram_en      = ram_en_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.cpu_overrun = overrun_q;
    assign bus.vid_ack     = vid_ack_q;
    assign bus.vid_rdata   = vid_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, shadow memory and
// latency/slot rules derived from the arbiter's intended behaviour.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int AW = RAM_ADDR_W;
    localparam int DW = RAM_DATA_W;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ram_arbiter_if bus ();

    ram_arbiter dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [DW-1:0] mem    [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    int n_tests = 0;
    int n_fail  = 0;

    // Synchronous single-port RAM: read-first, data valid the cycle after ram_en.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            bus.ram_rdata <= mem[bus.ram_addr];
            if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
    endtask

    task automatic apply_reset;
        reset_n = 1'b0;
        drive_idle();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic do_cpu(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output logic [7:0] rd);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        lat = -1; rd = '0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            bus.cpu_req = 1'b0;
            if (bus.cpu_ack === 1'b1) begin
                lat = i; rd = bus.cpu_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [43:0] outs;
        reset_n = 1'b0;
        drive_idle();
        tick();
        outs = {bus.cpu_ack, bus.cpu_overrun, bus.cpu_rdata, bus.vid_ack, bus.vid_rdata,
                bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata};
        n_tests++;
        if (outs !== 44'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_cpu_read_idle;
        apply_reset();
        mem[13'h0200] = 9'h141; shadow[13'h0200] = 9'h141;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0200;
        tick();
        n_tests++;
        if ({bus.ram_en, bus.ram_we, bus.ram_addr} !== {1'b1, 1'b0, 13'h0200}) begin
            n_fail++; $display("FAIL rd_issue_c1: got en=%b we=%b a=%h expected en=1 we=0 a=0200",
                               bus.ram_en, bus.ram_we, bus.ram_addr);
        end
        bus.cpu_req = 1'b0;
        tick();
        n_tests++;
        if (bus.cpu_ack !== 1'b0) begin
            n_fail++; $display("FAIL rd_early_ack_c2: got %b expected 0", bus.cpu_ack);
        end
        tick();
        n_tests++;
        if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, shadow[13'h0200][7:0]}) begin
            n_fail++; $display("FAIL rd_ack_c3: got ack=%b d=%h expected ack=1 d=%h",
                               bus.cpu_ack, bus.cpu_rdata, shadow[13'h0200][7:0]);
        end
        tick();
        n_tests++;
        if (bus.cpu_ack !== 1'b0) begin
            n_fail++; $display("FAIL rd_ack_pulse_c4: got %b expected 0", bus.cpu_ack);
        end
    endtask

    task automatic test_vid_then_cpu_write;
        int vack = -1, wr = -1, cack = -1, lat;
        logic [7:0] rd;
        apply_reset();
        bus.vid_req = 1'b1; bus.vid_addr = 13'h0200;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (bus.vid_ack === 1'b1 && vack < 0) begin
                vack = c;
                bus.vid_req = 1'b0;
                n_tests++;
                if (bus.vid_rdata !== shadow[13'h0200]) begin
                    n_fail++; $display("FAIL vid_data: got %h expected %h", bus.vid_rdata, shadow[13'h0200]);
                end
            end
            if (bus.ram_en === 1'b1 && bus.ram_we === 1'b1 && wr < 0) begin
                wr = c;
                n_tests++;
                if ({bus.ram_addr, bus.ram_wdata} !== {13'h0300, 9'h1AA}) begin
                    n_fail++; $display("FAIL wr_bus: got a=%h d=%h expected a=0300 d=1aa",
                                       bus.ram_addr, bus.ram_wdata);
                end
            end
            if (bus.cpu_ack === 1'b1 && cack < 0) cack = c;
            if (c == 1) begin
                bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0300; bus.cpu_wdata = 9'h1AA;
                shadow[13'h0300] = 9'h1AA;
            end else begin
                bus.cpu_req = 1'b0;
            end
        end
        n_tests++;
        if (vack != 3) begin n_fail++; $display("FAIL vid_ack_cycle: got %0d expected 3", vack); end
        n_tests++;
        if (wr != 4) begin n_fail++; $display("FAIL wr_cycle: got %0d expected 4", wr); end
        n_tests++;
        if (cack != 6) begin n_fail++; $display("FAIL wr_ack_cycle: got %0d expected 6", cack); end
        do_cpu(1'b0, 13'h0300, '0, lat, rd);
        n_tests++;
        if (lat != 3 || rd !== shadow[13'h0300][7:0]) begin
            n_fail++; $display("FAIL readback: got lat=%0d d=%h expected lat=3 d=%h", lat, rd, shadow[13'h0300][7:0]);
        end
    endtask

    task automatic test_random_mix;
        int req_cyc = 0, cpu_reqs = 0, cpu_acks = 0, vid_acks = 0, lat;
        bit outstanding = 0, exp_rd = 0;
        logic [7:0] exp_d = '0;
        apply_reset();
        bus.vid_req = 1'b1; bus.vid_addr = {1'b0, 12'($urandom)};
        for (int cyc = 0; cyc < 4096; cyc++) begin
            if (bus.cpu_ack === 1'b1) begin
                lat = cyc - req_cyc;
                n_tests++;
                if (!outstanding || lat < 3 || lat > 5) begin
                    n_fail++; $display("FAIL mix_cpu_latency: got %0d (pending=%0d) expected 3..5", lat, outstanding);
                end
                if (exp_rd) begin
                    n_tests++;
                    if (bus.cpu_rdata !== exp_d) begin
                        n_fail++; $display("FAIL mix_cpu_rdata: got %h expected %h", bus.cpu_rdata, exp_d);
                    end
                end
                outstanding = 0; cpu_acks++;
            end
            if (bus.vid_ack === 1'b1) begin
                n_tests++;
                if (bus.vid_rdata !== shadow[bus.vid_addr]) begin
                    n_fail++; $display("FAIL mix_vid_rdata: got %h expected %h at %h",
                                       bus.vid_rdata, shadow[bus.vid_addr], bus.vid_addr);
                end
                vid_acks++;
                bus.vid_addr = {1'b0, 12'($urandom)};
            end
            bus.cpu_req = 1'b0;
            if (cyc % 8 == 0 && cyc < 4088) begin
                n_tests++;
                if (outstanding) begin n_fail++; $display("FAIL mix_cpu_no_ack: got pending expected acked"); end
                bus.cpu_req   = 1'b1;
                bus.cpu_addr  = 13'($urandom);
                bus.cpu_we    = bus.cpu_addr[12] & 1'($urandom);
                bus.cpu_wdata = 9'($urandom);
                exp_rd = !bus.cpu_we;
                exp_d  = shadow[bus.cpu_addr][7:0];
                if (bus.cpu_we) shadow[bus.cpu_addr] = bus.cpu_wdata;
                outstanding = 1; req_cyc = cyc; cpu_reqs++;
            end
            tick();
        end
        bus.vid_req = 1'b0;
        repeat (6) tick();
        n_tests++;
        if (bus.cpu_overrun !== 1'b0) begin n_fail++; $display("FAIL mix_overrun: got %b expected 0", bus.cpu_overrun); end
        n_tests++;
        if (cpu_acks != cpu_reqs) begin n_fail++; $display("FAIL mix_cpu_count: got %0d expected %0d", cpu_acks, cpu_reqs); end
        // Every access costs issue + capture + decide, so the RAM yields one access per 3 cycles.
        n_tests++;
        if (cpu_acks + vid_acks < 4096 / 3 - 4) begin
            n_fail++; $display("FAIL mix_slot_use: got %0d accesses expected >= %0d", cpu_acks + vid_acks, 4096 / 3 - 4);
        end
    endtask

    task automatic test_overrun;
        int acks = 0;
        logic [7:0] first_d = '0, last_d = '0;
        apply_reset();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h1234;
        tick();
        bus.cpu_addr = 13'h0567;
        tick();
        bus.cpu_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.cpu_ack === 1'b1) begin
                if (acks == 0) first_d = bus.cpu_rdata;
                last_d = bus.cpu_rdata; acks++;
            end
            tick();
        end
        n_tests++;
        if (bus.cpu_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b expected 1", bus.cpu_overrun); end
        n_tests++;
        if (acks != 2) begin n_fail++; $display("FAIL overrun_acks: got %0d expected 2", acks); end
        n_tests++;
        if (first_d !== shadow[13'h1234][7:0]) begin
            n_fail++; $display("FAIL overrun_first: got %h expected %h", first_d, shadow[13'h1234][7:0]);
        end
        n_tests++;
        if (last_d !== shadow[13'h0567][7:0]) begin
            n_fail++; $display("FAIL overrun_second: got %h expected %h", last_d, shadow[13'h0567][7:0]);
        end
    endtask

    task automatic test_reset_mid_vid;
        int lat = -1;
        logic [43:0] outs;
        apply_reset();
        bus.vid_req = 1'b1; bus.vid_addr = 13'h00AB;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        outs = {bus.cpu_ack, bus.cpu_overrun, bus.cpu_rdata, bus.vid_ack, bus.vid_rdata,
                bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata};
        n_tests++;
        if (outs !== 44'd0) begin n_fail++; $display("FAIL async_reset_outs: got %h expected 0", outs); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (bus.vid_ack !== 1'b0) begin n_fail++; $display("FAIL reset_no_ack: got %b expected 0", bus.vid_ack); end
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus.vid_ack === 1'b1) begin
                lat = i;
                n_tests++;
                if (bus.vid_rdata !== shadow[13'h00AB]) begin
                    n_fail++; $display("FAIL reset_refetch_data: got %h expected %h", bus.vid_rdata, shadow[13'h00AB]);
                end
                break;
            end
        end
        bus.vid_req = 1'b0;
        n_tests++;
        if (lat != 3) begin n_fail++; $display("FAIL reset_refetch_lat: got %0d expected 3", lat); end
        tick();
    endtask

`ifdef RAM_ARB_PREFETCH_EN
    task automatic test_prefetch;
        bit seen = 0, got = 0;
        int lat;
        logic [7:0] rd;
        apply_reset();
        bus.vid_req = 1'b1; bus.vid_addr = 13'h1FFF;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (bus.vid_ack === 1'b1) begin got = 1; bus.vid_req = 1'b0; end
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.ram_en === 1'b1 && bus.ram_addr === 13'h0000) seen = 1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL pf_wrap: got no read of 0000 expected prefetch"); end
        do_cpu(1'b1, 13'h0000, 9'h155, lat, rd);
        shadow[13'h0000] = 9'h155;
        got = 0;
        bus.vid_req = 1'b1; bus.vid_addr = 13'h0000;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (bus.vid_ack === 1'b1) begin
                got = 1; bus.vid_req = 1'b0;
                n_tests++;
                if (bus.vid_rdata !== 9'h155) begin
                    n_fail++; $display("FAIL pf_stale: got %h expected 155", bus.vid_rdata);
                end
            end
        end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL pf_vid_ack: got none expected ack"); end
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]    = DW'((i * 37 + 5) % 512);
            shadow[i] = DW'((i * 37 + 5) % 512);
        end
        test_reset();
        test_cpu_read_idle();
        test_vid_then_cpu_write();
        test_random_mix();
        test_overrun();
        test_reset_mid_vid();
`ifdef RAM_ARB_PREFETCH_EN
        test_prefetch();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
